// File: rtl/disp_pkg.sv
// Shared constants, scan state type and hex-to-segment table for the 3-digit display scanner.
package disp_pkg;

  localparam logic [7:0] SEG_OFF  = 8'hFF;
  localparam logic [2:0] BAZA_OFF = 3'b111;

  typedef enum logic {BLANK, SHOW} scan_state_e;

  // Active-low {dp, g..a} with dp off, indexed by nibble value.
  localparam logic [7:0] SEG_TABLE [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble plus decimal point to active-low 7-segment pattern.
module hex_to_seg7
  import disp_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       dp,
  output logic [7:0] seg
);

  logic [7:0] pattern;

  always_comb begin
    pattern = SEG_TABLE[nibble];
    seg     = {~dp, pattern[6:0]};
  end

endmodule

// File: rtl/disp_scan_ctrl.sv
// Time-multiplexed scan controller for a 3-digit common-anode 7-segment display with
// shadow/active double buffering so digits only change at frame boundaries.
module disp_scan_ctrl
  import disp_pkg::*;
#(
  parameter int unsigned DIGIT_CYC = 50000,
  parameter int unsigned BLANK_CYC = 500
) (
  input  logic        iCLK,
  input  logic        iRST_N,
  input  logic        iEN,
  input  logic        iLOAD,
  input  logic [11:0] iDATA,
  input  logic [2:0]  iDP,
  input  logic        iLZB,
  output logic        oACK,
  output logic [7:0]  seg,
  output logic [2:0]  baza
);

  localparam int unsigned CW = (DIGIT_CYC > 1) ? $clog2(DIGIT_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(DIGIT_CYC - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYC);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    dig_q, dig_d;
  scan_state_e   state_q, state_d;

  logic [11:0] shadow_data_q, shadow_data_d;
  logic [2:0]  shadow_dp_q, shadow_dp_d;
  logic [11:0] active_data_q, active_data_d;
  logic [2:0]  active_dp_q, active_dp_d;
  logic        pend_q, pend_d;

  logic        ack_q;
  logic [7:0]  seg_q, seg_d;
  logic [2:0]  baza_q, baza_d;

  logic        wrap, frame_end, xfer;
  logic [3:0]  nib;
  logic        dp_sel, lzb_blank;
  logic [2:0]  base_sel;
  logic [7:0]  dec_seg;

  assign wrap      = (cnt_q == CNT_LAST);
  assign frame_end = wrap && (dig_q == 2'd2);
  // While disabled nothing is on screen, so shadow may move to active at any time.
  assign xfer      = !iEN || frame_end;

  always_comb begin : scan_next
    cnt_d   = cnt_q;
    dig_d   = dig_q;
    state_d = state_q;
    if (!iEN) begin
      cnt_d   = '0;
      dig_d   = 2'd0;
      state_d = BLANK;
    end else begin
      cnt_d = wrap ? '0 : cnt_q + 1'b1;
      if (wrap) begin
        dig_d = (dig_q == 2'd2) ? 2'd0 : dig_q + 2'd1;
      end
      unique case (state_q)
        BLANK:   if (!wrap && cnt_d >= BLANK_END) state_d = SHOW;
        SHOW:    if (wrap) state_d = BLANK;
        default: state_d = BLANK;
      endcase
    end
  end

  always_comb begin : buffer_next
    shadow_data_d = shadow_data_q;
    shadow_dp_d   = shadow_dp_q;
    active_data_d = active_data_q;
    active_dp_d   = active_dp_q;
    pend_d        = pend_q;
    if (iLOAD) begin
      shadow_data_d = iDATA;
      shadow_dp_d   = iDP;
      if (xfer) begin
        active_data_d = iDATA;
        active_dp_d   = iDP;
        pend_d        = 1'b0;
      end else begin
        pend_d = 1'b1;
      end
    end else if (xfer && pend_q) begin
      active_data_d = shadow_data_q;
      active_dp_d   = shadow_dp_q;
      pend_d        = 1'b0;
    end
  end

  always_comb begin : digit_mux
    nib       = active_data_q[3:0];
    dp_sel    = active_dp_q[0];
    base_sel  = 3'b110;
    lzb_blank = 1'b0;
    case (dig_q)
      2'd1: begin
        nib       = active_data_q[7:4];
        dp_sel    = active_dp_q[1];
        base_sel  = 3'b101;
        lzb_blank = iLZB && (active_data_q[11:4] == 8'd0);
      end
      2'd2: begin
        nib       = active_data_q[11:8];
        dp_sel    = active_dp_q[2];
        base_sel  = 3'b011;
        lzb_blank = iLZB && (active_data_q[11:8] == 4'd0);
      end
      default: ;
    endcase
  end

  hex_to_seg7 u_dec (
    .nibble (nib),
    .dp     (dp_sel),
    .seg    (dec_seg)
  );

  always_comb begin : out_next
    seg_d  = SEG_OFF;
    baza_d = BAZA_OFF;
    if (iEN && state_q == SHOW) begin
      if (!lzb_blank) begin
        seg_d  = dec_seg;
        baza_d = base_sel;
      end else if (dp_sel) begin
        // Blanked digit still lights its decimal point alone.
        seg_d  = 8'h7F;
        baza_d = base_sel;
      end
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      cnt_q         <= '0;
      dig_q         <= 2'd0;
      state_q       <= BLANK;
      shadow_data_q <= 12'd0;
      shadow_dp_q   <= 3'd0;
      active_data_q <= 12'd0;
      active_dp_q   <= 3'd0;
      pend_q        <= 1'b0;
      ack_q         <= 1'b0;
      seg_q         <= SEG_OFF;
      baza_q        <= BAZA_OFF;
    end else begin
      cnt_q         <= cnt_d;
      dig_q         <= dig_d;
      state_q       <= state_d;
      shadow_data_q <= shadow_data_d;
      shadow_dp_q   <= shadow_dp_d;
      active_data_q <= active_data_d;
      active_dp_q   <= active_dp_d;
      pend_q        <= pend_d;
      ack_q         <= iLOAD;
      seg_q         <= seg_d;
      baza_q        <= baza_d;
    end
  end

  assign oACK = ack_q;
  assign seg  = seg_q;
  assign baza = baza_q;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Directed bench for disp_scan_ctrl: a frame-position model checked every cycle, plus
// hand-computed literal pins at key points of each scenario.
module tb_disp_scan_ctrl;

  localparam int P_DIG = 8;
  localparam int P_BLK = 2;
  localparam int FRAME = 3 * P_DIG;

  localparam logic [7:0] HEX7 [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  logic        iCLK = 1'b0;
  logic        iRST_N;
  logic        iEN;
  logic        iLOAD;
  logic [11:0] iDATA;
  logic [2:0]  iDP;
  logic        iLZB;
  logic        oACK;
  logic [7:0]  seg;
  logic [2:0]  baza;

  int checks = 0;
  int errors = 0;
  logic cmp_en = 1'b0;

  always #5 iCLK = ~iCLK;

  disp_scan_ctrl #(
    .DIGIT_CYC (P_DIG),
    .BLANK_CYC (P_BLK)
  ) dut (
    .iCLK   (iCLK),
    .iRST_N (iRST_N),
    .iEN    (iEN),
    .iLOAD  (iLOAD),
    .iDATA  (iDATA),
    .iDP    (iDP),
    .iLZB   (iLZB),
    .oACK   (oACK),
    .seg    (seg),
    .baza   (baza)
  );

  // Expected {seg, baza} for a given position inside the frame.
  function automatic logic [10:0] model_out(input logic en, input int p, input logic [11:0] d,
                                            input logic [2:0] dp, input logic lzb);
    int         dg;
    logic [3:0] n;
    logic [2:0] base;
    logic [7:0] pat;
    logic       blank;
    if (!en) return {8'hFF, 3'b111};
    dg = p / P_DIG;
    if ((p % P_DIG) < P_BLK) return {8'hFF, 3'b111};
    n        = d[dg*4 +: 4];
    base     = 3'b111;
    base[dg] = 1'b0;
    blank    = lzb && ((dg == 2 && d[11:8] == 4'd0) || (dg == 1 && d[11:4] == 8'd0));
    if (blank) return dp[dg] ? {8'h7F, base} : {8'hFF, 3'b111};
    pat = HEX7[n];
    return {~dp[dg], pat[6:0], base};
  endfunction

  int          pos;
  logic [11:0] m_act, m_sh;
  logic [2:0]  m_actdp, m_shdp;
  logic        m_pend;
  logic [7:0]  exp_seg;
  logic [2:0]  exp_baza;
  logic        exp_ack;
  logic [10:0] m_out;
  logic        m_xfer;

  assign m_out  = model_out(iEN, pos, m_act, m_actdp, iLZB);
  assign m_xfer = !iEN || (pos == FRAME - 1);

  always @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      pos      <= 0;
      m_act    <= '0;
      m_actdp  <= '0;
      m_sh     <= '0;
      m_shdp   <= '0;
      m_pend   <= 1'b0;
      exp_seg  <= 8'hFF;
      exp_baza <= 3'b111;
      exp_ack  <= 1'b0;
    end else begin
      exp_ack               <= iLOAD;
      {exp_seg, exp_baza}   <= m_out;
      if (iLOAD) begin
        m_sh   <= iDATA;
        m_shdp <= iDP;
        if (m_xfer) begin
          m_act   <= iDATA;
          m_actdp <= iDP;
          m_pend  <= 1'b0;
        end else begin
          m_pend <= 1'b1;
        end
      end else if (m_xfer && m_pend) begin
        m_act   <= m_sh;
        m_actdp <= m_shdp;
        m_pend  <= 1'b0;
      end
      pos <= iEN ? ((pos == FRAME - 1) ? 0 : pos + 1) : 0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge iCLK) begin
    if (cmp_en) begin
      chk("model_seg", 32'(seg), 32'(exp_seg));
      chk("model_baza", 32'(baza), 32'(exp_baza));
      chk("model_ack", 32'(oACK), 32'(exp_ack));
    end
  end

  task automatic pin(input string name, input logic [7:0] s, input logic [2:0] b);
    chk({name, "_seg"}, 32'(seg), 32'(s));
    chk({name, "_baza"}, 32'(baza), 32'(b));
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge iCLK);
    #1;
  endtask

  initial begin
    iRST_N = 1'b0;
    iEN    = 1'b1;
    iLOAD  = 1'b0;
    iDATA  = 12'h000;
    iDP    = 3'b000;
    iLZB   = 1'b0;
    repeat (2) @(posedge iCLK);
    cmp_en = 1'b1;
    step(3);
    iRST_N = 1'b1;
    pin("reset", 8'hFF, 3'b111);
    chk("reset_ack", 32'(oACK), 32'd0);

    // Edges 0,1 blank; 2..7 digit0; 10 digit1; 18 digit2.
    step(1); pin("blank0", 8'hFF, 3'b111);
    step(1); pin("blank1", 8'hFF, 3'b111);
    step(1); pin("zero_d0", 8'hC0, 3'b110);
    step(8); pin("zero_d1", 8'hC0, 3'b101);
    step(8); pin("zero_d2", 8'hC0, 3'b011);

    // Load 1A8 / dp on digit1, sampled mid digit2 slot.
    iLOAD = 1'b1; iDATA = 12'h1A8; iDP = 3'b010;
    step(1); iLOAD = 1'b0; chk("ack_pulse", 32'(oACK), 32'd1);
    step(1); chk("ack_drop", 32'(oACK), 32'd0);
    step(6);  pin("load_d0", 8'h80, 3'b110);
    step(8);  pin("load_d1", 8'h08, 3'b101);
    step(8);  pin("load_d2", 8'hF9, 3'b011);

    // Load during digit1 SHOW must not tear the current frame.
    step(16);
    iLOAD = 1'b1; iDATA = 12'h123; iDP = 3'b000;
    step(1); iLOAD = 1'b0; pin("tear_d1_old", 8'h08, 3'b101);
    step(7); pin("tear_d2_old", 8'hF9, 3'b011);
    step(8); pin("tear_d0_new", 8'hB0, 3'b110);

    // Leading-zero blanking.
    iLZB = 1'b1; iLOAD = 1'b1; iDATA = 12'h005; iDP = 3'b000;
    step(1); iLOAD = 1'b0;
    step(23); pin("lzb_d0", 8'h92, 3'b110);
    step(8);  pin("lzb_d1", 8'hFF, 3'b111);
    step(8);  pin("lzb_d2", 8'hFF, 3'b111);
    iLOAD = 1'b1; iDATA = 12'h005; iDP = 3'b100;
    step(1); iLOAD = 1'b0;
    step(23); pin("lzb_d2_dp", 8'h7F, 3'b011);

    // Pending load then disable mid-SHOW; resume shows the pending value.
    iLOAD = 1'b1; iDATA = 12'h4E7; iDP = 3'b001;
    step(1); iLOAD = 1'b0; iEN = 1'b0;
    chk("dis_ack", 32'(oACK), 32'd1);
    step(1); pin("disabled", 8'hFF, 3'b111);
    step(9); iEN = 1'b1;
    step(1); pin("resume_blank", 8'hFF, 3'b111);
    step(2); pin("resume_d0", 8'h78, 3'b110);
    step(8); pin("resume_d1", 8'h86, 3'b101);

    // Asynchronous reset mid-frame.
    #2 iRST_N = 1'b0;
    #1 pin("async_rst", 8'hFF, 3'b111);
    chk("async_rst_ack", 32'(oACK), 32'd0);
    @(posedge iCLK); #1 iRST_N = 1'b1;

    // Load on the boundary cycle goes straight to active.
    step(23);
    iLOAD = 1'b1; iDATA = 12'hFFF; iDP = 3'b000;
    step(1); iLOAD = 1'b0; chk("bound_ack", 32'(oACK), 32'd1);
    step(3); pin("bound_d0", 8'h8E, 3'b110);

    // Back-to-back loads: both acknowledged, last one shown.
    iLOAD = 1'b1; iDATA = 12'h111;
    step(1); chk("b2b_ack0", 32'(oACK), 32'd1); iDATA = 12'h222;
    step(1); chk("b2b_ack1", 32'(oACK), 32'd1); iLOAD = 1'b0;
    step(1); chk("b2b_ack2", 32'(oACK), 32'd0);
    step(21); pin("b2b_d0", 8'hA4, 3'b110);
    step(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
